// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice reused
// once per cycle across NIBBLES slices of the operands.
//
// state | meaning
// IDLE  | ready for a request, in_ready high
// ADD   | one nibble per cycle through the lookahead slice, busy high
// DONE  | result held on sum/cout/ovf with out_valid high until taken
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            last_nib;

  logic [3:0]      x, y, g, p, s;
  logic [4:0]      c;

  // Lookahead slice: every carry expanded directly from the slice carry-in.
  always_comb begin
    x    = a_reg[4*idx +: 4];
    y    = b_reg[4*idx +: 4];
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = carry_reg;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = x ^ y ^ c[3:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign last_nib = (state == ADD) && (idx == LAST_IDX);

  // Operand capture on accept, then one result nibble per ADD cycle.
  // Subtraction is folded into capture: B inverted and carry-in forced high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b ^ {W{sub}};
      carry_reg <= sub | cin;
      idx       <= '0;
    end else if (state == ADD) begin
      sum[4*idx +: 4] <= s;
      carry_reg       <= c[4];
      idx             <= idx + IDXW'(1);
      if (last_nib) begin
        cout <= c[4];
        ovf  <= c[3] ^ c[4];
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed vectors on a 4-nibble instance,
// then back-to-back random traffic on 1-, 4- and 8-nibble instances.
// Expected results go into per-instance queues; monitors pop and compare.
module tb_nibble_serial_add_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        in_valid[3], out_ready[3], sub_i[3], cin_i[3];
  logic [31:0] a_i[3], b_i[3];
  logic        in_ready[3], out_valid[3], cout_o[3], ovf_o[3], busy_o[3];
  logic [3:0]  sum1;
  logic [15:0] sum4;
  logic [31:0] sum8;
  logic [31:0] sum_o[3];
  bit          prev_ov[3];
  int          last_acc[3];

  exp_t q0[$], q1[$], q2[$];

  always_comb begin
    sum_o[0] = 32'(sum1);
    sum_o[1] = 32'(sum4);
    sum_o[2] = sum8;
  end

  nibble_serial_add_ctrl #(.NIBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sub(sub_i[0]), .cin(cin_i[0]), .a(a_i[0][3:0]), .b(b_i[0][3:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum1),
    .cout(cout_o[0]), .ovf(ovf_o[0]), .busy(busy_o[0]));

  nibble_serial_add_ctrl #(.NIBBLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sub(sub_i[1]), .cin(cin_i[1]), .a(a_i[1][15:0]), .b(b_i[1][15:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum4),
    .cout(cout_o[1]), .ovf(ovf_o[1]), .busy(busy_o[1]));

  nibble_serial_add_ctrl #(.NIBBLES(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sub(sub_i[2]), .cin(cin_i[2]), .a(a_i[2]), .b(b_i[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum8),
    .cout(cout_o[2]), .ovf(ovf_o[2]), .busy(busy_o[2]));

  function automatic int nib(int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int qfront_acc(int k);
    case (k)
      0:       return q0[0].acc_cyc;
      1:       return q1[0].acc_cyc;
      default: return q2[0].acc_cyc;
    endcase
  endfunction

  task automatic qpush(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic exp_t mk(logic [31:0] s, logic c, logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.acc_cyc = 0;
    return e;
  endfunction

  // Reference: plain W-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(logic [31:0] av, logic [31:0] bv,
                                 logic sv, logic cv, int w);
    exp_t e;
    logic [31:0] m, aa, bb;
    logic [32:0] full;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa   = av & m;
    bb   = (sv ? ~bv : bv) & m;
    full = {1'b0, aa} + {1'b0, bb} + 33'(sv ? 1'b1 : cv);
    e.sum     = full[31:0] & m;
    e.cout    = full[w];
    e.ovf     = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic flag(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: latency on out_valid rise, result compare on each handshake.
  task automatic mon(int k);
    exp_t e;
    if (!rst_n) begin
      prev_ov[k] = 1'b0;
      return;
    end
    if (out_valid[k] && !prev_ov[k]) begin
      if (qsize(k) == 0) flag($sformatf("unexpected_out_valid n%0d", nib(k)));
      else chk($sformatf("latency n%0d", nib(k)), 32'(cyc - qfront_acc(k)), 32'(nib(k)));
    end
    if (out_valid[k] && out_ready[k] && qsize(k) > 0) begin
      qpop(k, e);
      chk($sformatf("sum n%0d", nib(k)), sum_o[k], e.sum);
      chk($sformatf("cout n%0d", nib(k)), 32'(cout_o[k]), 32'(e.cout));
      chk($sformatf("ovf n%0d", nib(k)), 32'(ovf_o[k]), 32'(e.ovf));
    end
    prev_ov[k] = out_valid[k];
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    always @(negedge clk) mon(gi);
  end

  // Offer one request, record the accepting edge and the expected result.
  task automatic send(int k, logic [31:0] av, logic [31:0] bv, logic sv,
                      logic cv, exp_t e, bit hold);
    int t;
    @(posedge clk);
    #1;
    a_i[k] = av; b_i[k] = bv; sub_i[k] = sv; cin_i[k] = cv; in_valid[k] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[k]) begin
      flag($sformatf("accept_timeout n%0d", nib(k)));
      in_valid[k] = 1'b0;
      return;
    end
    e.acc_cyc = cyc + 1;
    if (hold && last_acc[k] >= 0)
      chk($sformatf("b2b_period n%0d", nib(k)), 32'(e.acc_cyc - last_acc[k]), 32'(nib(k) + 2));
    last_acc[k] = e.acc_cyc;
    qpush(k, e);
    @(posedge clk);
    #1;
    if (!hold) in_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(int k);
    int t;
    t = 0;
    while (qsize(k) > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (qsize(k) > 0) begin
      flag($sformatf("drain_timeout n%0d", nib(k)));
      case (k)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end
  endtask

  task automatic rand_run(int k);
    logic [31:0] av, bv, m;
    logic        sv, cv;
    int          w;
    w = 4 * nib(k);
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    last_acc[k] = -1;
    repeat (334) begin
      av = $urandom & m;
      bv = $urandom & m;
      sv = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      send(k, av, bv, sv, cv, model(av, bv, sv, cv, w), 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    wait_drain(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; sub_i[i] = 1'b0; cin_i[i] = 1'b0;
      a_i[i] = '0; b_i[i] = '0; last_acc[i] = -1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready[1]), 32'd1);
    chk("rst out_valid", 32'(out_valid[1]), 32'd0);
    chk("rst busy", 32'(busy_o[1]), 32'd0);
    chk("rst sum", sum_o[1], 32'h0);
    chk("rst cout", 32'(cout_o[1]), 32'd0);
    chk("rst ovf", 32'(ovf_o[1]), 32'd0);
    rst_n = 1'b1;
    out_ready[1] = 1'b1;

    send(1, 32'h1234, 32'h4321, 1'b0, 1'b0, mk(32'h5555, 1'b0, 1'b0), 1'b0);
    chk("busy in ADD", 32'(busy_o[1]), 32'd1);
    chk("in_ready in ADD", 32'(in_ready[1]), 32'd0);
    wait_drain(1);
    send(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, mk(32'h0000, 1'b1, 1'b0), 1'b0);
    wait_drain(1);
    send(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1), 1'b0);
    wait_drain(1);
    send(1, 32'h00FF, 32'h0F00, 1'b0, 1'b1, mk(32'h1000, 1'b0, 1'b0), 1'b0);
    wait_drain(1);
    send(1, 32'h8000, 32'h0001, 1'b1, 1'b0, mk(32'h7FFF, 1'b1, 1'b1), 1'b0);
    wait_drain(1);
    send(1, 32'h0005, 32'h0003, 1'b1, 1'b1, mk(32'h0002, 1'b1, 1'b0), 1'b0);
    wait_drain(1);

    // Backpressure: result must hold while new offers are ignored.
    out_ready[1] = 1'b0;
    send(1, 32'h0003, 32'h0005, 1'b1, 1'b0, mk(32'hFFFE, 1'b0, 1'b0), 1'b0);
    in_valid[1] = 1'b1; a_i[1] = 32'hAAAA; b_i[1] = 32'h5555; sub_i[1] = 1'b0;
    for (int t = 0; t < 20 && !out_valid[1]; t++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall out_valid", 32'(out_valid[1]), 32'd1);
      chk("stall in_ready", 32'(in_ready[1]), 32'd0);
      chk("stall sum", sum_o[1], 32'hFFFE);
      chk("stall cout", 32'(cout_o[1]), 32'd0);
      chk("stall ovf", 32'(ovf_o[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    wait_drain(1);

    // Reset during the second ADD cycle aborts with no result.
    send(1, 32'h1111, 32'h2222, 1'b0, 1'b0, mk(32'h3333, 1'b0, 1'b0), 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("abort out_valid", 32'(out_valid[1]), 32'd0);
    chk("abort busy", 32'(busy_o[1]), 32'd0);
    chk("abort in_ready", 32'(in_ready[1]), 32'd1);
    chk("abort sum", sum_o[1], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    a_i[1] = 32'h0001; b_i[1] = 32'h0001; sub_i[1] = 1'b0; cin_i[1] = 1'b0;
    in_valid[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      e = mk(32'h0002, 1'b0, 1'b0);
      e.acc_cyc = cyc + 1;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    chk("accept after reset", 32'(busy_o[1]), 32'd1);
    wait_drain(1);

    for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
